// File: rtl/regfile_multiport.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_multiport
//  Purpose  : Parametrised, clocked register file. Holds DEPTH registers of
//             DATA_W bits. Accepts one write per cycle, which is either
//             external data or a register-to-register copy (MOV). Provides
//             two registered read ports with write-first bypass. The array
//             clears itself with a sequential sweep after reset or when a
//             clear is requested.
//  Ports    : clk, reset        - clock and synchronous active-high reset
//             wr_en/wr_addr/    - external write port
//             wr_data
//             mov_en/mov_src    - register copy regs[mov_src] -> wr_addr
//             rd_en/rd_addr1/2  - read request, sampled on the rising edge
//             rd_data1/2        - registered read data
//             rd_valid          - one-cycle pulse when rd_data1/2 are updated
//             clear_req         - start a full clear sweep
//             busy              - clear sweep in progress, requests ignored
//  Revision : 1.0 - initial release
// ============================================================================
module regfile_multiport #(
    parameter  int DATA_W   = 32,
    parameter  int DEPTH    = 32,
    parameter  int ZERO_REG = 0,
    localparam int ADDR_W   = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              mov_en,
    input  logic [ADDR_W-1:0] mov_src,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2,
    output logic              rd_valid,
    input  logic              clear_req,
    output logic              busy
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam logic [ADDR_W-1:0] c_last_addr = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] c_zero_addr = '0;
    localparam logic              c_zero_reg  = (ZERO_REG != 0);

    // ------------------------------------------------------------------
    // State machine encoding
    // ------------------------------------------------------------------
    typedef enum logic [0:0] {
        S_CLEAR = 1'b0,
        S_IDLE  = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [ADDR_W-1:0]   r_clr_ptr;
    logic [ADDR_W-1:0]   w_clr_ptr_next;

    // Storage array. It has no reset so that it maps onto RAM; the clear
    // sweep zeroes it one entry per cycle instead.
    logic [DATA_W-1:0]   r_regs [DEPTH];

    logic [DATA_W-1:0]   r_rd_data1;
    logic [DATA_W-1:0]   r_rd_data2;
    logic                r_rd_valid;

    // ------------------------------------------------------------------
    // Request qualification
    // ------------------------------------------------------------------
    logic                w_idle_accept;   // IDLE and no clear this cycle
    logic                w_wr_req;        // a write or MOV is requested
    logic                w_wr_discard;    // write to hard-wired zero register
    logic                w_wr_commit;     // array is updated this cycle
    logic [DATA_W-1:0]   w_wr_value;      // value committed by write/MOV
    logic                w_rd_accept;
    logic [DATA_W-1:0]   w_rd_value1;
    logic [DATA_W-1:0]   w_rd_value2;
    logic                w_sweep_write;

    // A clear request in IDLE takes the whole cycle: any write, MOV or read
    // presented alongside it is dropped.
    assign w_idle_accept = (r_state == S_IDLE) && !clear_req;

    assign w_wr_req      = wr_en || mov_en;
    assign w_wr_discard  = c_zero_reg && (wr_addr == c_zero_addr);
    assign w_wr_commit   = w_idle_accept && w_wr_req && !w_wr_discard;

    // External data has priority over a MOV. The MOV source is the pre-edge
    // array content, so a self-copy (mov_src == wr_addr) is a no-op.
    assign w_wr_value    = wr_en ? wr_data : r_regs[mov_src];

    assign w_rd_accept   = w_idle_accept && rd_en;

    assign w_sweep_write = (r_state == S_CLEAR);

    // ------------------------------------------------------------------
    // Read path with write-first bypass. A committed write to the address
    // being read is forwarded so the port sees the new value. A discarded
    // write never commits, so it is never forwarded.
    // ------------------------------------------------------------------
    always_comb begin
        w_rd_value1 = r_regs[rd_addr1];
        w_rd_value2 = r_regs[rd_addr2];

        if (w_wr_commit && (wr_addr == rd_addr1)) begin
            w_rd_value1 = w_wr_value;
        end
        if (w_wr_commit && (wr_addr == rd_addr2)) begin
            w_rd_value2 = w_wr_value;
        end

        // The zero register reads as zero whatever the array holds.
        if (c_zero_reg && (rd_addr1 == c_zero_addr)) begin
            w_rd_value1 = '0;
        end
        if (c_zero_reg && (rd_addr2 == c_zero_addr)) begin
            w_rd_value2 = '0;
        end
    end

    // ------------------------------------------------------------------
    // State machine: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next   = r_state;
        w_clr_ptr_next = r_clr_ptr;

        case (r_state)
            S_CLEAR: begin
                // One entry cleared per cycle; leave after the last one.
                w_clr_ptr_next = r_clr_ptr + 1'b1;
                if (r_clr_ptr == c_last_addr) begin
                    w_state_next = S_IDLE;
                end
            end
            S_IDLE: begin
                if (clear_req) begin
                    w_state_next   = S_CLEAR;
                    w_clr_ptr_next = '0;
                end
            end
            default: begin
                w_state_next   = S_CLEAR;
                w_clr_ptr_next = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State machine: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_CLEAR;
            r_clr_ptr <= '0;
        end else begin
            r_state   <= w_state_next;
            r_clr_ptr <= w_clr_ptr_next;
        end
    end

    // ------------------------------------------------------------------
    // Array write port: the sweep and the functional write share a single
    // port and are mutually exclusive by state. Nothing is written while
    // reset is asserted.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (w_sweep_write) begin
                r_regs[r_clr_ptr] <= '0;
            end else if (w_wr_commit) begin
                r_regs[wr_addr] <= w_wr_value;
            end
        end
    end

    // ------------------------------------------------------------------
    // Registered read outputs. Data holds when no read is accepted.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_data1 <= '0;
            r_rd_data2 <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= w_rd_accept;
            if (w_rd_accept) begin
                r_rd_data1 <= w_rd_value1;
                r_rd_data2 <= w_rd_value2;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign rd_data1 = r_rd_data1;
    assign rd_data2 = r_rd_data2;
    assign rd_valid = r_rd_valid;
    assign busy     = (r_state == S_CLEAR);

endmodule
`default_nettype wire

// File: tb/tb_regfile_multiport.sv
`default_nettype none
// ============================================================================
//  Module   : tb_regfile_multiport
//  Purpose  : Self-checking bench for regfile_multiport. Two instances share
//             all inputs: one with ZERO_REG=0 and one with ZERO_REG=1.
//             Read expectations are queued when a read is issued and a
//             monitor compares them whenever rd_valid is seen.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_multiport;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 32;
    localparam int ADDR_W = $clog2(DEPTH);

    logic              clk = 1'b0;
    logic              reset;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              mov_en;
    logic [ADDR_W-1:0] mov_src;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr1;
    logic [ADDR_W-1:0] rd_addr2;
    logic              clear_req;

    logic [DATA_W-1:0] d0_rd_data1, d0_rd_data2, dz_rd_data1, dz_rd_data2;
    logic              d0_rd_valid, dz_rd_valid, d0_busy, dz_busy;

    regfile_multiport #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ZERO_REG(0)) u_d0 (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .mov_en(mov_en), .mov_src(mov_src), .rd_en(rd_en),
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .rd_data1(d0_rd_data1),
        .rd_data2(d0_rd_data2), .rd_valid(d0_rd_valid),
        .clear_req(clear_req), .busy(d0_busy)
    );

    regfile_multiport #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ZERO_REG(1)) u_dz (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .mov_en(mov_en), .mov_src(mov_src), .rd_en(rd_en),
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .rd_data1(dz_rd_data1),
        .rd_data2(dz_rd_data2), .rd_valid(dz_rd_valid),
        .clear_req(clear_req), .busy(dz_busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int              at;
        logic [DATA_W-1:0] e1, e2, z1, z2;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // ------------------------------------------------------------------
    // Monitor: compares every rd_valid pulse against the queue
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        if (!reset && (d0_rd_valid || dz_rd_valid)) begin
            exp_t e;
            checks++;
            if (!(d0_rd_valid && dz_rd_valid) || exp_q.size() == 0) begin
                errors++;
                $display("FAIL rd_valid_unexpected cyc=%0d d0_valid=%0b dz_valid=%0b queued=%0d required a pending read on both",
                         cyc, d0_rd_valid, dz_rd_valid, exp_q.size());
            end else begin
                e = exp_q.pop_front();
                if (e.at != cyc || d0_rd_data1 !== e.e1 || d0_rd_data2 !== e.e2 ||
                    dz_rd_data1 !== e.z1 || dz_rd_data2 !== e.z2) begin
                    errors++;
                    $display("FAIL read_data cyc=%0d got d0=%h/%h dz=%h/%h required cyc=%0d d0=%h/%h dz=%h/%h",
                             cyc, d0_rd_data1, d0_rd_data2, dz_rd_data1, dz_rd_data2,
                             e.at, e.e1, e.e2, e.z1, e.z2);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (inputs change 1 time unit after the rising edge)
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        wr_en = 0; wr_addr = '0; wr_data = '0; mov_en = 0; mov_src = '0;
        rd_en = 0; rd_addr1 = '0; rd_addr2 = '0; clear_req = 0;
    endtask

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s got=%0h required=%0h", name, got, req);
        end
    endtask

    // Issue a read (optionally with whatever write fields the caller set)
    // and queue the expected data for both instances.
    task automatic do_read(input int a1, input int a2,
                           input logic [DATA_W-1:0] e1, input logic [DATA_W-1:0] e2);
        exp_t e;
        rd_en = 1; rd_addr1 = ADDR_W'(a1); rd_addr2 = ADDR_W'(a2);
        e.at = cyc + 1;
        e.e1 = e1; e.e2 = e2;
        e.z1 = (a1 == 0) ? '0 : e1;
        e.z2 = (a2 == 0) ? '0 : e2;
        exp_q.push_back(e);
        tick();
        idle_in();
    endtask

    task automatic do_write(input int a, input logic [DATA_W-1:0] d);
        wr_en = 1; wr_addr = ADDR_W'(a); wr_data = d;
        tick();
        idle_in();
    endtask

    // Count cycles with busy high; the sweep is hammered with requests
    // that must all be ignored.
    task automatic measure_busy(input string name);
        int n = 0;
        while (d0_busy && n < 100) begin
            wr_en = 1; wr_addr = 5'd2; wr_data = 32'hDEAD_BEEF;
            rd_en = 1; rd_addr1 = 5'd2; mov_en = 1; clear_req = n[0];
            tick();
            n++;
        end
        idle_in();
        check(name, 64'(n), 64'd32);
        check({name, "_z"}, 64'(dz_busy), 64'd0);
    endtask

    initial begin
        idle_in();
        reset = 1;
        tick(); tick();
        // Reset state
        check("reset_busy", 64'(d0_busy), 64'd1);
        check("reset_busy_z", 64'(dz_busy), 64'd1);
        check("reset_valid", 64'(d0_rd_valid), 64'd0);
        check("reset_rd_data", {d0_rd_data1, d0_rd_data2}, 64'd0);

        reset = 0;
        measure_busy("busy_after_reset");

        // Every register reads zero after the initial sweep
        for (int i = 0; i < DEPTH; i++) do_read(i, DEPTH - 1 - i, 32'h0, 32'h0);

        // r0 write: plain register without ZERO_REG, hard zero with it
        do_write(0, 32'h7);
        do_read(0, 0, 32'h7, 32'h7);

        // Write then MOV, read both source and destination
        do_write(3, 32'h1234);
        mov_en = 1; wr_addr = 5'd5; mov_src = 5'd3; tick(); idle_in();
        do_read(5, 3, 32'h1234, 32'h1234);

        // Same-cycle write and read: bypass
        wr_en = 1; wr_addr = 5'd9; wr_data = 32'hA;
        do_read(9, 9, 32'hA, 32'hA);

        // wr_en beats mov_en
        wr_en = 1; mov_en = 1; wr_addr = 5'd4; wr_data = 32'hB; mov_src = 5'd3;
        tick(); idle_in();
        do_read(4, 3, 32'hB, 32'h1234);

        // Self-MOV is a no-op; MOV bypass into port 2
        mov_en = 1; wr_addr = 5'd5; mov_src = 5'd5; tick(); idle_in();
        mov_en = 1; wr_addr = 5'd6; mov_src = 5'd4;
        do_read(5, 6, 32'h1234, 32'hB);

        // MOV into r0 with a same-cycle read (discarded write not bypassed)
        mov_en = 1; wr_addr = 5'd0; mov_src = 5'd3;
        do_read(0, 9, 32'h1234, 32'hA);

        // rd_en low: outputs hold
        tick(); tick();
        check("hold_rd_data", {d0_rd_data1, d0_rd_data2}, {32'h1234, 32'hA});

        // Fill everything, then clear with a simultaneous write
        for (int i = 0; i < DEPTH; i++) do_write(i, 32'h100 + i);
        do_read(31, 0, 32'h11F, 32'h100);
        clear_req = 1; wr_en = 1; wr_addr = 5'd1; wr_data = 32'hFF;
        rd_en = 1; rd_addr1 = 5'd1;
        tick(); idle_in();
        check("clear_busy_start", 64'(d0_busy), 64'd1);
        measure_busy("busy_after_clear");
        for (int i = 0; i < DEPTH; i++) do_read(i, (i + 7) % DEPTH, 32'h0, 32'h0);

        // Reset in the middle of a sweep
        do_write(7, 32'h77);
        do_read(7, 7, 32'h77, 32'h77);
        clear_req = 1; tick(); idle_in();
        repeat (10) tick();
        reset = 1; tick(); reset = 0;
        check("midsweep_rd_data", {d0_rd_data1, d0_rd_data2}, 64'd0);
        check("midsweep_rd_data_z", {dz_rd_data1, dz_rd_data2}, 64'd0);
        measure_busy("busy_after_midsweep_reset");
        do_read(7, 31, 32'h0, 32'h0);

        tick(); tick();
        check("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
